// File: rtl/ir_nec_decoder_if.sv
// rtl/ir_nec_decoder_if.sv - Output handshake bundle of the NEC IR decoder
// Signals:
//   cmd[31:0]   received frame, first bit on air in cmd[0]
//   valid       cmd/repeat_flag hold a frame for the consumer
//   ready       consumer accepts cmd when valid & ready
//   repeat_flag held output is a repeat code (cmd = last good frame)
//   err         one-cycle pulse on decode error, inverse-check failure or overrun
// Modports: master = decoder side, slave = consumer side.
interface ir_nec_decoder_if;
    logic [31:0] cmd;
    logic        valid;
    logic        ready;
    logic        repeat_flag;
    logic        err;

    modport master (output cmd, output valid, output repeat_flag, output err, input ready);
    modport slave  (input cmd, input valid, input repeat_flag, input err, output ready);
endinterface

// File: rtl/ir_nec_decoder.sv
// rtl/ir_nec_decoder.sv - NEC IR envelope decoder with valid/ready frame output
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-low reset (0 = reset)
//   i_ir_in  asynchronous demodulated IR envelope
//   o_frame  ir_nec_decoder_if.master: cmd, valid, repeat_flag, err out; ready in
module ir_nec_decoder #(
    parameter int CLK_FREQ      = 25000000,
    parameter int UNIT_US       = 562,
    parameter int LEAD_MARK_U   = 16,
    parameter int LEAD_SPACE_U  = 8,
    parameter int RPT_SPACE_U   = 4,
    parameter int TOL_PCT       = 25,
    parameter bit IR_ACTIVE_LOW = 1'b1,
    parameter bit CHECK_INV     = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ir_in,
    ir_nec_decoder_if.master o_frame
);
    localparam int UNIT_CYC = (CLK_FREQ / 1000000) * UNIT_US;
    localparam int SAT_CYC  = 2 * LEAD_MARK_U * UNIT_CYC;
    localparam int CW       = $clog2(SAT_CYC + 1);
    localparam int TOL_LO   = 100 - TOL_PCT;
    localparam int TOL_HI   = 100 + TOL_PCT;

    localparam logic [CW-1:0] CNT_SAT = CW'(SAT_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] LM_LO = CW'(LEAD_MARK_U * UNIT_CYC * TOL_LO / 100);
    localparam logic [CW-1:0] LM_HI = CW'(LEAD_MARK_U * UNIT_CYC * TOL_HI / 100);
    localparam logic [CW-1:0] LS_LO = CW'(LEAD_SPACE_U * UNIT_CYC * TOL_LO / 100);
    localparam logic [CW-1:0] LS_HI = CW'(LEAD_SPACE_U * UNIT_CYC * TOL_HI / 100);
    localparam logic [CW-1:0] RS_LO = CW'(RPT_SPACE_U * UNIT_CYC * TOL_LO / 100);
    localparam logic [CW-1:0] RS_HI = CW'(RPT_SPACE_U * UNIT_CYC * TOL_HI / 100);
    localparam logic [CW-1:0] B1_LO = CW'(UNIT_CYC * TOL_LO / 100);
    localparam logic [CW-1:0] B1_HI = CW'(UNIT_CYC * TOL_HI / 100);
    localparam logic [CW-1:0] B3_LO = CW'(3 * UNIT_CYC * TOL_LO / 100);
    localparam logic [CW-1:0] B3_HI = CW'(3 * UNIT_CYC * TOL_HI / 100);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_RPT_STOP
    } state_t;

    state_t        r_state;
    logic [1:0]    r_sync;
    logic          r_mark_d;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_shift;
    logic [31:0]   r_cmd;
    logic [4:0]    r_bit_cnt;
    logic          r_valid;
    logic          r_rpt;
    logic          r_err;
    logic          r_have;

    logic w_mark, w_edge, w_timeout;
    logic w_lm, w_ls, w_rs, w_b1, w_b3;
    logic w_inv_ok, w_busy, w_dlv_data, w_dlv_rpt;

    function automatic logic in_win(input logic [CW-1:0] d, input logic [CW-1:0] lo,
                                    input logic [CW-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // mark=1 regardless of receiver polarity
    assign w_mark = r_sync[1] ^ IR_ACTIVE_LOW;
    assign w_edge = w_mark ^ r_mark_d;

    // r_cnt holds the length of the level that just ended when w_edge is high
    assign w_lm = in_win(r_cnt, LM_LO, LM_HI);
    assign w_ls = in_win(r_cnt, LS_LO, LS_HI);
    assign w_rs = in_win(r_cnt, RS_LO, RS_HI);
    assign w_b1 = in_win(r_cnt, B1_LO, B1_HI);
    assign w_b3 = in_win(r_cnt, B3_LO, B3_HI);

    assign w_timeout  = (r_state != S_IDLE) && !w_edge && (r_cnt == CNT_SAT);
    assign w_dlv_data = (r_state == S_STOP_MARK) && w_edge && w_b1;
    assign w_dlv_rpt  = (r_state == S_RPT_STOP) && w_edge && w_b1;
    assign w_inv_ok   = !CHECK_INV || (r_shift[31:24] == ~r_shift[23:16]);
    // held output not being taken this cycle: a new deliver would overrun it
    assign w_busy     = r_valid && !o_frame.ready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync   <= {2{IR_ACTIVE_LOW}};
            r_mark_d <= 1'b0;
            r_cnt    <= CNT_SAT;
        end else begin
            r_sync   <= {r_sync[0], i_ir_in};
            r_mark_d <= w_mark;
            if (w_edge) begin
                r_cnt <= CNT_ONE;
            end else if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_cmd     <= '0;
            r_valid   <= 1'b0;
            r_rpt     <= 1'b0;
            r_err     <= 1'b0;
            r_have    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_valid && o_frame.ready) begin
                r_valid <= 1'b0;
            end

            if (w_dlv_data) begin
                if (!w_inv_ok || w_busy) begin
                    r_err <= 1'b1;
                end else begin
                    r_cmd   <= r_shift;
                    r_rpt   <= 1'b0;
                    r_valid <= 1'b1;
                    r_have  <= 1'b1;
                end
            end

            if (w_dlv_rpt) begin
                if (!r_have || w_busy) begin
                    r_err <= 1'b1;
                end else begin
                    r_rpt   <= 1'b1;
                    r_valid <= 1'b1;
                end
            end

            if (w_timeout) begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
            end else if (w_edge) begin
                // levels alternate, so every edge outside IDLE ends the level the state measures
                case (r_state)
                    S_IDLE: begin
                        if (w_mark) r_state <= S_LEAD_MARK;
                    end
                    S_LEAD_MARK: begin
                        if (w_lm) begin
                            r_state <= S_LEAD_SPACE;
                        end else begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end
                    end
                    S_LEAD_SPACE: begin
                        if (w_ls) begin
                            r_state   <= S_BIT_MARK;
                            r_bit_cnt <= '0;
                        end else if (w_rs) begin
                            r_state <= S_RPT_STOP;
                        end else begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end
                    end
                    S_BIT_MARK: begin
                        if (w_b1) begin
                            r_state <= S_BIT_SPACE;
                        end else begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end
                    end
                    S_BIT_SPACE: begin
                        if (w_b1 || w_b3) begin
                            // right shift so the first bit on air ends in [0]
                            r_shift   <= {w_b3, r_shift[31:1]};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            r_state   <= (r_bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                        end else begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end
                    end
                    S_STOP_MARK, S_RPT_STOP: begin
                        r_state <= S_IDLE;
                        if (!w_b1) r_err <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_frame.cmd         = r_cmd;
    assign o_frame.valid       = r_valid;
    assign o_frame.repeat_flag = r_rpt;
    assign o_frame.err         = r_err;
endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb/tb_ir_nec_decoder.sv - Randomized scoreboard bench for ir_nec_decoder
module tb_ir_nec_decoder;
    localparam int U   = 16;   // cycles per NEC unit with CLK_FREQ=1 MHz, UNIT_US=16
    localparam int TOL = 25;
    localparam int GAP = 600;  // idle after a frame, longer than the 512-cycle timeout

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ir    = 1'b1;
    always #5 clk = ~clk;

    ir_nec_decoder_if bus();

    ir_nec_decoder #(
        .CLK_FREQ(1000000), .UNIT_US(U), .LEAD_MARK_U(16), .LEAD_SPACE_U(8),
        .RPT_SPACE_U(4), .TOL_PCT(TOL), .IR_ACTIVE_LOW(1'b1), .CHECK_INV(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_ir_in(ir), .o_frame(bus)
    );

    typedef struct { logic [31:0] cmd; logic rpt; } out_t;
    out_t exp_out[$];
    int   exp_err[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [31:0] m_last = '0;
    bit   m_have = 1'b0;
    bit   m_busy = 1'b0;
    int   durs[$];
    int   noms[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int lo(input int n); return U * n * (100 - TOL) / 100; endfunction
    function automatic int hi(input int n); return U * n * (100 + TOL) / 100; endfunction
    function automatic bit win(input int d, input int n); return d >= lo(n) && d <= hi(n); endfunction

    task automatic add(input int n);
        noms.push_back(n);
        durs.push_back(U * n);
    endtask

    task automatic build_data(input logic [31:0] c);
        durs.delete(); noms.delete();
        add(16); add(8);
        for (int i = 0; i < 32; i++) begin
            add(1);
            add(c[i] ? 3 : 1);
        end
        add(1);
    endtask

    task automatic build_rpt();
        durs.delete(); noms.delete();
        add(16); add(4); add(1);
    endtask

    task automatic set_ready(input bit r);
        @(negedge clk);
        bus.ready = r;
        if (r) m_busy = 1'b0;
    endtask

    task automatic send_n(input int len);
        @(negedge clk);
        for (int k = 0; k < len; k++) begin
            ir = (k % 2 == 0) ? 1'b0 : 1'b1;
            repeat (durs[k]) @(negedge clk);
        end
        ir = 1'b1;
    endtask

    // Parses the duration list by the NEC grammar, queues the expected response, sends the parsed part
    task automatic run_frame();
        int len; bit bad; bit is_rpt; logic [31:0] val; int m; int s;
        bad = 1'b0; is_rpt = 1'b0; val = '0; len = 1;
        if (!win(durs[0], 16)) begin
            bad = 1'b1;
        end else if (win(durs[1], 8)) begin
            len = 2;
            for (int i = 0; i < 32 && !bad; i++) begin
                m = durs[2 + 2 * i];
                s = durs[3 + 2 * i];
                len++;
                if (!win(m, 1)) begin
                    bad = 1'b1;
                end else begin
                    len++;
                    if (win(s, 3)) val = val | (32'd1 << i);
                    else if (!win(s, 1)) bad = 1'b1;
                end
            end
            if (!bad) begin
                len++;
                if (!win(durs[66], 1)) bad = 1'b1;
            end
        end else if (win(durs[1], 4)) begin
            is_rpt = 1'b1;
            len = 3;
            if (!win(durs[2], 1)) bad = 1'b1;
        end else begin
            bad = 1'b1;
            len = 2;
        end

        if (bad) begin
            exp_err.push_back(1);
        end else if (is_rpt) begin
            if (!m_have || m_busy) exp_err.push_back(2);
            else begin
                exp_out.push_back('{m_last, 1'b1});
                m_busy = !bus.ready;
            end
        end else begin
            if (val[31:24] != ~val[23:16] || m_busy) exp_err.push_back(3);
            else begin
                exp_out.push_back('{val, 1'b0});
                m_last = val;
                m_have = 1'b1;
                m_busy = !bus.ready;
            end
        end
        send_n(len);
    endtask

    task automatic frame_gap();
        repeat (GAP) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ir    = 1'b1;
        #1;
        check({tag, "_cmd"},   bus.cmd, 32'h0);
        check({tag, "_valid"}, {31'd0, bus.valid}, 32'd0);
        check({tag, "_rpt"},   {31'd0, bus.repeat_flag}, 32'd0);
        check({tag, "_err"},   {31'd0, bus.err}, 32'd0);
        exp_out.delete();
        m_have = 1'b0;
        m_busy = 1'b0;
        #100;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: sample just before each rising edge, when ready and outputs are settled
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                if (bus.err === 1'b1) begin
                    check("err_expected", 32'(exp_err.size() != 0), 32'd1);
                    if (exp_err.size() != 0) void'(exp_err.pop_front());
                end
                if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
                    check("out_expected", 32'(exp_out.size() != 0), 32'd1);
                    if (exp_out.size() != 0) begin
                        e = exp_out.pop_front();
                        check("out_cmd", bus.cmd, e.cmd);
                        check("out_repeat", {31'd0, bus.repeat_flag}, {31'd0, e.rpt});
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] c;
        int k;
        bus.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd",   bus.cmd, 32'h0);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_err",   {31'd0, bus.err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // valid frame, ready held low, then three-edge latency and a one-cycle accept
        build_data(32'h9F600707);
        run_frame();
        @(posedge clk); @(posedge clk); #1;
        check("latency_edge2", {31'd0, bus.valid}, 32'd0);
        @(posedge clk); #1;
        check("latency_edge3", {31'd0, bus.valid}, 32'd1);
        check("t1_cmd", bus.cmd, 32'h9F600707);
        repeat (20) @(negedge clk);
        bus.ready = 1'b1;
        m_busy = 1'b0;
        @(negedge clk);
        bus.ready = 1'b0;
        check("t1_consume", {31'd0, bus.valid}, 32'd0);
        frame_gap();

        // repeat code with a stored frame, then without one after reset
        set_ready(1'b1);
        build_rpt(); run_frame(); frame_gap();
        do_reset("t2_rst");
        build_rpt(); run_frame(); frame_gap();

        // inverse-check failure
        build_data(32'h9E600707); run_frame(); frame_gap();

        // overrun: second frame dropped while the first is held
        set_ready(1'b0);
        build_data(32'h9D620707); run_frame(); frame_gap();
        build_data(32'h9A650707); run_frame(); frame_gap();
        check("t4_hold", bus.cmd, 32'h9D620707);
        set_ready(1'b1);
        repeat (3) @(negedge clk);

        // tolerance edges, timeout, recovery
        build_data(32'h9F600707); durs[0] = 199; run_frame(); frame_gap();
        build_data(32'h9F600707); durs[0] = 185; run_frame(); frame_gap();
        build_data(32'h6A956C93); durs[0] = 192; durs[1] = 160; run_frame(); frame_gap();
        build_data(32'h9F600707); durs[0] = 321; run_frame(); frame_gap();
        build_data(32'h9F600707); durs[12] = 569; run_frame(); frame_gap();
        build_data(32'h55AA00FF); run_frame(); frame_gap();

        // reset during bit 10 while an output is held
        set_ready(1'b0);
        build_data(32'h10EF20DF); run_frame(); frame_gap();
        build_data(32'h08F7C03F);
        send_n(22);
        ir = 1'b0;
        repeat (5) @(negedge clk);
        do_reset("t6_rst");
        set_ready(1'b1);
        build_data(32'h08F7C03F); run_frame(); frame_gap();

        // randomized frames with in-window jitter and occasional boundary violations
        for (int it = 0; it < 8; it++) begin
            set_ready(1'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) begin
                build_rpt();
            end else begin
                c = $urandom;
                if ($urandom_range(3, 0) != 0) c[31:24] = ~c[23:16];
                build_data(c);
            end
            for (int j = 0; j < durs.size(); j++) durs[j] = int'($urandom_range(hi(noms[j]), lo(noms[j])));
            if ($urandom_range(4, 0) == 0) begin
                k = int'($urandom_range(durs.size() - 1, 0));
                durs[k] = ($urandom_range(1, 0) == 1) ? lo(noms[k]) - 1 : hi(noms[k]) + 1;
            end
            run_frame();
            frame_gap();
        end

        set_ready(1'b1);
        repeat (10) @(negedge clk);
        check("drain_out", 32'(exp_out.size()), 32'd0);
        check("drain_err", 32'(exp_err.size()), 32'd0);
        check("final_valid", {31'd0, bus.valid}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
